pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Parametrised pipeline controller: merges per-stage stall requests into a hold vector,
//  issues branch/jump redirects with multi-cycle flush of younger stages, and takes a
//  single maskable interrupt through a small FSM (redirect to vector, capture EPC, ack).
//  Sits beside the pipeline; drives every stage register's hold/flush and the PC redirect.
// PARAMETERS
//  NSTAGE      6   number of pipeline stages; index 0 = PC (youngest), NSTAGE-1 = oldest
//  AW          32  address width
//  JUMP_STAGE  3   stage resolving jumps (1..NSTAGE-1); stages below it are flushed on redirect
//  FLUSH_CYC   1   cycles flush stays asserted per redirect (>=1; covers fetch latency)
// PORTS
//  clk             in   1       clock, all state on rising edge
//  rst_n           in   1       asynchronous active-low reset
//  stall_req       in   NSTAGE  per-stage stall request (bit i from stage i)
//  jump_flag       in   1       redirect request from JUMP_STAGE
//  jump_addr       in   AW      redirect target
//  irq_req         in   1       level interrupt request
//  irq_en          in   1       global interrupt enable
//  irq_vector      in   AW      interrupt handler address
//  irq_epc_in      in   AW      PC of instruction currently in JUMP_STAGE
//  ctrl_jump_flag  out  1       PC redirect strobe
//  ctrl_jump_addr  out  AW      PC redirect target
//  stall           out  NSTAGE  hold vector, bit i holds stage i
//  flush           out  NSTAGE  flush vector, bit i bubbles stage i
//  irq_ack         out  1       one-cycle pulse when interrupt taken
//  epc_out         out  AW      registered exception return PC
//  busy            out  1       FSM not IDLE
// BEHAVIOUR
//  - rst_n low: FSM=IDLE, flush counter=0, epc_out=0; all outputs 0 (combinational outputs gated).
//  - FSM states: IDLE, IRQ_TAKE, FLUSH.
//  - Stall merge (comb): h = highest i with stall_req[i]; stall[h:0]=1, rest 0; none -> 0.
//  - Priority each cycle: jump_flag > FSM redirect/flush > stall merge > interrupt take.
//  - Jump (any state): ctrl_jump_flag=1, ctrl_jump_addr=jump_addr same cycle (0 latency);
//    flush[JUMP_STAGE-1:0]=1, stall=0. If FLUSH_CYC>1 -> FLUSH, counter=FLUSH_CYC-1; else IDLE.
//    Jump in FLUSH reloads counter (restart).
//  - IDLE -> IRQ_TAKE when irq_req & irq_en & !jump_flag & stall_req==0.
//  - IRQ_TAKE (exactly 1 cycle): ctrl_jump_flag=1, ctrl_jump_addr=irq_vector, irq_ack=1,
//    flush[JUMP_STAGE:0]=1 (interrupted instr re-executes), epc_out<=irq_epc_in;
//    next FLUSH (counter=FLUSH_CYC-1) if FLUSH_CYC>1, else IDLE. jump_flag here wins: no ack, no EPC.
//  - FLUSH: flush[JUMP_STAGE-1:0]=1; stall_req bits below JUMP_STAGE ignored, bits >= JUMP_STAGE
//    still merged (stall wins over flush on a given stage); counter-- each cycle, IDLE at 0.
//  - No interrupt taken in IRQ_TAKE/FLUSH; irq_req held is taken on return to IDLE.
//  - busy = (state != IDLE). epc_out changes only in IRQ_TAKE.
//  - Reset asserted mid-FLUSH/IRQ_TAKE: immediate IDLE, outputs 0, no ack.
// TESTING
//  1 reset: rst_n=0 with all inputs active -> stall=0, flush=0, ctrl_jump_flag=0, epc_out=0.
//  2 stall_req=6'b000100 -> stall=6'b000111; 6'b100100 -> 6'b111111; 0 -> 0 next cycle.
//  3 FLUSH_CYC=3, jump_flag=1 addr=0x80 one cycle -> ctrl_jump 0x80 same cycle, flush=6'b000111
//    for 3 cycles, busy high for 2, then IDLE.
//  4 irq_req=1 irq_en=1 irq_epc_in=0x100 vector=0x20, no stalls -> next cycle IRQ_TAKE:
//    irq_ack=1, redirect 0x20, flush=6'b001111; following cycle epc_out=0x100.
//  5 irq_req with stall_req=6'b010000 -> no ack until stall drops; irq_en=0 -> never acked.
//  6 jump_flag coincident with IRQ_TAKE -> redirect=jump_addr, irq_ack=0, epc unchanged;
//    irq retaken after flush ends.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall-request merge, jump/interrupt redirect with younger-stage flush, single IRQ FSM.
// Latency: redirect, stall and flush are combinational (0 cycles); an interrupt is taken the cycle after it qualifies.
// Backpressure: any stall request holds off interrupt entry; a jump overrides everything, including a pending take.
module pipe_ctrl #(
    parameter int NSTAGE     = 6,
    parameter int AW         = 32,
    parameter int JUMP_STAGE = 3,
    parameter int FLUSH_CYC  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NSTAGE-1:0] stall_req,
    input  logic              jump_flag,
    input  logic [AW-1:0]     jump_addr,
    input  logic              irq_req,
    input  logic              irq_en,
    input  logic [AW-1:0]     irq_vector,
    input  logic [AW-1:0]     irq_epc_in,
    output logic              ctrl_jump_flag,
    output logic [AW-1:0]     ctrl_jump_addr,
    output logic [NSTAGE-1:0] stall,
    output logic [NSTAGE-1:0] flush,
    output logic              irq_ack,
    output logic [AW-1:0]     epc_out,
    output logic              busy
);

    localparam int CW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_CYC - 1);
    localparam logic [NSTAGE-1:0] ONES = '1;
    localparam logic [NSTAGE-1:0] JMP_MASK = ONES >> (NSTAGE - JUMP_STAGE);
    localparam logic [NSTAGE-1:0] IRQ_MASK = ONES >> (NSTAGE - JUMP_STAGE - 1);

    typedef enum logic [1:0] {IDLE, IRQ_TAKE, FLUSH} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [AW-1:0] epc;
    logic          epc_ld;

    // Holding stage h also holds every younger stage behind it.
    function automatic logic [NSTAGE-1:0] merge(input logic [NSTAGE-1:0] req);
        logic [NSTAGE-1:0] m;
        logic              acc;
        m   = '0;
        acc = 1'b0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            acc  = acc | req[i];
            m[i] = acc;
        end
        return m;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            epc   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (epc_ld) begin
                epc <= irq_epc_in;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        epc_ld         = 1'b0;
        ctrl_jump_flag = 1'b0;
        ctrl_jump_addr = '0;
        stall          = '0;
        flush          = '0;
        irq_ack        = 1'b0;

        if (jump_flag) begin
            ctrl_jump_flag = 1'b1;
            ctrl_jump_addr = jump_addr;
            flush          = JMP_MASK;
            state_nxt      = (FLUSH_CYC > 1) ? FLUSH : IDLE;
            cnt_nxt        = CNT_INIT;
        end else begin
            case (state)
                IRQ_TAKE: begin
                    ctrl_jump_flag = 1'b1;
                    ctrl_jump_addr = irq_vector;
                    irq_ack        = 1'b1;
                    flush          = IRQ_MASK;
                    epc_ld         = 1'b1;
                    state_nxt      = (FLUSH_CYC > 1) ? FLUSH : IDLE;
                    cnt_nxt        = CNT_INIT;
                end
                FLUSH: begin
                    // Younger stages are being bubbled anyway; only older stages may still hold.
                    stall = merge(stall_req & ~JMP_MASK);
                    flush = JMP_MASK & ~stall;
                    if (cnt <= CW'(1)) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - CW'(1);
                    end
                end
                default: begin
                    stall = merge(stall_req);
                    if (irq_req && irq_en && (stall_req == '0)) begin
                        state_nxt = IRQ_TAKE;
                    end
                end
            endcase
        end

        if (!rst_n) begin
            ctrl_jump_flag = 1'b0;
            ctrl_jump_addr = '0;
            stall          = '0;
            flush          = '0;
            irq_ack        = 1'b0;
            epc_ld         = 1'b0;
        end
    end

    assign epc_out = epc;
    assign busy    = rst_n && (state != IDLE);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomised + directed bench for pipe_ctrl with a queue scoreboard and a cycle-level reference model.
module tb_pipe_ctrl;
    localparam int NS = 6;
    localparam int AW = 32;
    localparam int JS = 3;
    localparam int FC = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NS-1:0] stall_req;
    logic          jump_flag;
    logic [AW-1:0] jump_addr;
    logic          irq_req;
    logic          irq_en;
    logic [AW-1:0] irq_vector;
    logic [AW-1:0] irq_epc_in;
    logic          ctrl_jump_flag;
    logic [AW-1:0] ctrl_jump_addr;
    logic [NS-1:0] stall;
    logic [NS-1:0] flush;
    logic          irq_ack;
    logic [AW-1:0] epc_out;
    logic          busy;

    pipe_ctrl #(.NSTAGE(NS), .AW(AW), .JUMP_STAGE(JS), .FLUSH_CYC(FC)) dut (
        .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .jump_flag(jump_flag),
        .jump_addr(jump_addr), .irq_req(irq_req), .irq_en(irq_en), .irq_vector(irq_vector),
        .irq_epc_in(irq_epc_in), .ctrl_jump_flag(ctrl_jump_flag), .ctrl_jump_addr(ctrl_jump_addr),
        .stall(stall), .flush(flush), .irq_ack(irq_ack), .epc_out(epc_out), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          jf;
        logic [AW-1:0] ja;
        logic [NS-1:0] st;
        logic [NS-1:0] fl;
        logic          ack;
        logic [AW-1:0] epc;
        logic          busy;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   done     = 0;

    // Reference model: "take pending this cycle", cycles of flush still owed, saved EPC.
    bit            m_take;
    int            m_left;
    logic [AW-1:0] m_epc;
    int            ack_count;

    function automatic logic [NS-1:0] hold_of(input logic [NS-1:0] req);
        int h;
        h = -1;
        for (int i = 0; i < NS; i++) if (req[i]) h = i;
        return NS'((64'd1 << (h + 1)) - 64'd1);
    endfunction

    task automatic model_step();
        exp_t e;
        logic [NS-1:0] young;
        young = NS'((1 << JS) - 1);
        e.jf = 0; e.ja = '0; e.st = '0; e.fl = '0; e.ack = 0;
        if (!rst_n) begin
            m_take = 0; m_left = 0; m_epc = '0;
            e.epc = '0; e.busy = 0;
            exp_q.push_back(e);
            return;
        end
        e.epc  = m_epc;
        e.busy = m_take || (m_left > 0);
        if (jump_flag) begin
            e.jf = 1; e.ja = jump_addr; e.fl = young;
            m_take = 0; m_left = FC - 1;
        end else if (m_take) begin
            e.jf = 1; e.ja = irq_vector; e.ack = 1;
            e.fl = NS'((1 << (JS + 1)) - 1);
            m_epc = irq_epc_in;
            m_take = 0; m_left = FC - 1;
            ack_count++;
        end else if (m_left > 0) begin
            e.st = hold_of(stall_req & ~young);
            e.fl = young & ~e.st;
            m_left--;
        end else begin
            e.st = hold_of(stall_req);
            if (irq_req && irq_en && stall_req == '0) m_take = 1;
        end
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: every negedge the DUT's outputs are compared with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ctrl_jump_flag", 64'(ctrl_jump_flag), 64'(e.jf));
                if (e.jf) chk("ctrl_jump_addr", 64'(ctrl_jump_addr), 64'(e.ja));
                chk("stall", 64'(stall), 64'(e.st));
                chk("flush", 64'(flush), 64'(e.fl));
                chk("irq_ack", 64'(irq_ack), 64'(e.ack));
                chk("epc_out", 64'(epc_out), 64'(e.epc));
                chk("busy", 64'(busy), 64'(e.busy));
            end
        end
    end

    task automatic step(input logic r, input logic [NS-1:0] sr, input logic jf, input logic [AW-1:0] ja,
                        input logic irq, input logic en, input logic [AW-1:0] vec, input logic [AW-1:0] epc);
        rst_n = r; stall_req = sr; jump_flag = jf; jump_addr = ja;
        irq_req = irq; irq_en = en; irq_vector = vec; irq_epc_in = epc;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, '0, 0, '0, 0, 1, 32'h20, 32'h100);
    endtask

    initial begin
        int acks_before;
        rst_n = 0; stall_req = '0; jump_flag = 0; jump_addr = '0;
        irq_req = 0; irq_en = 0; irq_vector = '0; irq_epc_in = '0;
        m_take = 0; m_left = 0; m_epc = '0; ack_count = 0;
        @(posedge clk);
        #1;
        // Reset with every input active.
        step(0, '1, 1, 32'h80, 1, 1, 32'h20, 32'h100);
        step(0, '1, 1, 32'h80, 1, 1, 32'h20, 32'h100);
        // Stall merge.
        step(1, 6'b000100, 0, '0, 0, 0, '0, '0);
        step(1, 6'b100100, 0, '0, 0, 0, '0, '0);
        step(1, 6'b000000, 0, '0, 0, 0, '0, '0);
        // Jump with 3-cycle flush.
        step(1, '0, 1, 32'h80, 0, 0, '0, '0);
        idle(4);
        // Interrupt take and EPC capture.
        step(1, '0, 0, '0, 1, 1, 32'h20, 32'h100);
        step(1, '0, 0, '0, 1, 1, 32'h20, 32'h100);
        idle(4);
        // Stall blocks interrupt; disabled interrupt is never taken.
        for (int i = 0; i < 4; i++) step(1, 6'b010000, 0, '0, 1, 1, 32'h24, 32'h200);
        step(1, '0, 0, '0, 1, 1, 32'h24, 32'h200);
        step(1, '0, 0, '0, 0, 1, 32'h24, 32'h200);
        idle(3);
        acks_before = ack_count;
        for (int i = 0; i < 6; i++) step(1, '0, 0, '0, 1, 0, 32'h28, 32'h300);
        chk("irq_en_low_no_ack_model", 64'(ack_count), 64'(acks_before));
        // Jump coincident with IRQ_TAKE, interrupt retaken after flush.
        step(1, '0, 0, '0, 1, 1, 32'h30, 32'h400);
        step(1, '0, 1, 32'h44, 1, 1, 32'h30, 32'h400);
        for (int i = 0; i < 5; i++) step(1, '0, 0, '0, 1, 1, 32'h30, 32'h500);
        idle(4);
        // Stall during flush on an older stage, then reset mid-flush.
        step(1, '0, 1, 32'h90, 0, 0, '0, '0);
        step(1, 6'b010010, 0, '0, 0, 0, '0, '0);
        step(0, '0, 0, '0, 1, 1, '0, '0);
        idle(3);
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [NS-1:0] sr;
            sr = ($urandom_range(0, 3) == 0) ? NS'($urandom) : '0;
            step(($urandom_range(0, 299) != 0), sr, ($urandom_range(0, 9) == 0), $urandom,
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0), $urandom, $urandom);
        end
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
